// File: rtl/cont2_pkg.sv
// cont2_pkg: shared types and defaults for the "type 2" triangular counter
// controller.
//   state_t    - controller FSM states
//   DEF_WIDTH  - default counter width
//   DEF_DWELL  - default hold length at MAX and at 0
//   cycle_len  - number of clock edges in one full up/down period
package cont2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UP,
        TOP,
        DOWN,
        BOTTOM,
        DONE
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DWELL = 2;

    // The ramps each take MAX-1 steps between the two holds (the first value
    // after a hold is already one away from the hold value).
    function automatic int cycle_len(input int width, input int dwell);
        return 2 * ((2 ** width) - 2) + 2 * dwell;
    endfunction

endpackage

// File: rtl/cont_updown.sv
// cont_updown: loadable up/down counter datapath.
//   Clock   - rising-edge clock
//   Reset   - synchronous active-high, clears Q
//   Load    - load LoadVal (highest priority)
//   LoadVal - value loaded when Load is high
//   Inc     - increment Q (priority over Dec)
//   Dec     - decrement Q
//   Q       - counter value
// The counter does not saturate; the controller never asks it to step past
// either end of the range.
module cont_updown #(
    parameter int WIDTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             Inc,
    input  logic             Dec,
    output logic [WIDTH-1:0] Q
);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Q <= '0;
        end else if (Load) begin
            Q <= LoadVal;
        end else if (Inc) begin
            Q <= Q + 1'b1;
        end else if (Dec) begin
            Q <= Q - 1'b1;
        end
    end

endmodule

// File: rtl/cont2_ctrl.sv
// cont2_ctrl: sequencing controller for the triangular up/down counter.
// Counts 1..MAX, holds MAX for DWELL cycles, counts down to 0, holds 0 for
// DWELL cycles, and repeats Cycles times (0 = until Stop).
//   Clock  - rising-edge clock
//   Reset  - synchronous active-high, overrides all other inputs
//   Start  - begin a run (only honoured in IDLE, and only without Stop)
//   Stop   - abort a run; returns to IDLE on the next edge
//   Cycles - number of full periods, latched when Start is accepted
//   Out    - counter value
//   Dir    - high while ramping up or holding at MAX
//   Busy   - run in progress
//   Done   - one-cycle pulse on normal completion
// All outputs are registered.
module cont2_ctrl
    import cont2_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DWELL = DEF_DWELL
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stop,
    input  logic [3:0]       Cycles,
    output logic [WIDTH-1:0] Out,
    output logic             Dir,
    output logic             Busy,
    output logic             Done
);

    if (DWELL < 1 || DWELL > 15) begin : g_bad_dwell
        $error("cont2_ctrl: DWELL must be in the range 1..15");
    end

    if (WIDTH < 2) begin : g_bad_width
        $error("cont2_ctrl: WIDTH must be at least 2");
    end

    localparam logic [WIDTH-1:0] MAXV       = '1;
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
    localparam logic [3:0]       DWELL_INIT = 4'(DWELL - 1);

    state_t           state_q, state_d;
    logic [3:0]       dwell_q, dwell_d;
    logic [3:0]       loop_q, loop_d;
    logic             dir_q, busy_q, done_q;

    logic             ld, inc, dec;
    logic [WIDTH-1:0] ld_val;

    cont_updown #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .Clock  (Clock),
        .Reset  (Reset),
        .Load   (ld),
        .LoadVal(ld_val),
        .Inc    (inc),
        .Dec    (dec),
        .Q      (Out)
    );

    // Next-state and datapath control.
    // The final period of a run ends one cycle early: the DONE cycle itself
    // stands in for the last bottom hold cycle, so completion lands exactly
    // N periods minus one edge after Start. With DWELL=1 that means going
    // straight from DOWN to DONE.
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        loop_d  = loop_q;
        ld      = 1'b0;
        ld_val  = '0;
        inc     = 1'b0;
        dec     = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start && !Stop) begin
                    state_d = UP;
                    ld      = 1'b1;
                    ld_val  = ONE;
                    loop_d  = Cycles;
                end
            end

            UP: begin
                if (Stop) begin
                    state_d = IDLE;
                    ld      = 1'b1;
                end else begin
                    inc = 1'b1;
                    if (Out == MAXV - ONE) begin
                        state_d = TOP;
                        dwell_d = DWELL_INIT;
                    end
                end
            end

            TOP: begin
                if (Stop) begin
                    state_d = IDLE;
                    ld      = 1'b1;
                end else if (dwell_q == 4'd0) begin
                    state_d = DOWN;
                    dec     = 1'b1;
                end else begin
                    dwell_d = dwell_q - 4'd1;
                end
            end

            DOWN: begin
                if (Stop) begin
                    state_d = IDLE;
                    ld      = 1'b1;
                end else begin
                    dec = 1'b1;
                    if (Out == ONE) begin
                        if (loop_q == 4'd1 && DWELL == 1) begin
                            state_d = DONE;
                        end else begin
                            state_d = BOTTOM;
                            dwell_d = DWELL_INIT;
                        end
                    end
                end
            end

            BOTTOM: begin
                if (Stop) begin
                    state_d = IDLE;
                    ld      = 1'b1;
                end else if (loop_q == 4'd1 && dwell_q == 4'd1) begin
                    state_d = DONE;
                end else if (dwell_q == 4'd0) begin
                    state_d = UP;
                    ld      = 1'b1;
                    ld_val  = ONE;
                    // A latched count of 0 means "run forever".
                    if (loop_q != 4'd0) begin
                        loop_d = loop_q - 4'd1;
                    end
                end else begin
                    dwell_d = dwell_q - 4'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                ld      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            dwell_q <= 4'd0;
            loop_q  <= 4'd0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            loop_q  <= loop_d;
            dir_q   <= (state_d == UP) || (state_d == TOP);
            busy_q  <= (state_d == UP) || (state_d == TOP) ||
                       (state_d == DOWN) || (state_d == BOTTOM);
            done_q  <= (state_d == DONE);
        end
    end

    assign Dir  = dir_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_cont2_ctrl.sv
module tb_cont2_ctrl;

    logic       Clock  = 1'b0;
    logic       Reset  = 1'b1;
    logic       Start  = 1'b0;
    logic       Stop   = 1'b0;
    logic [3:0] Cycles = 4'd0;

    logic [3:0] out0;
    logic       dir0, busy0, done0;
    logic [2:0] out1;
    logic       dir1, busy1, done1;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    always #5 Clock = ~Clock;

    cont2_ctrl #(.WIDTH(4), .DWELL(2)) dut0 (
        .Clock (Clock),
        .Reset (Reset),
        .Start (Start),
        .Stop  (Stop),
        .Cycles(Cycles),
        .Out   (out0),
        .Dir   (dir0),
        .Busy  (busy0),
        .Done  (done0)
    );

    cont2_ctrl #(.WIDTH(3), .DWELL(1)) dut1 (
        .Clock (Clock),
        .Reset (Reset),
        .Start (Start),
        .Stop  (Stop),
        .Cycles(Cycles),
        .Out   (out1),
        .Dir   (dir1),
        .Busy  (busy1),
        .Done  (done1)
    );

    // Reference model: a run is just a position t within the period plus the
    // number of periods left; outputs follow from t by plain arithmetic.
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    typedef struct packed {
        int mode;
        int t;
        int rem;
    } ms_t;

    ms_t m0 = '{mode: M_IDLE, t: 0, rem: 0};
    ms_t m1 = '{mode: M_IDLE, t: 0, rem: 0};

    function automatic int period(input int mx, input int dw);
        return 2 * (mx - 1) + 2 * dw;
    endfunction

    function automatic ms_t step(input ms_t s, input int mx, input int dw,
                                 input bit rst, input bit st, input bit sp,
                                 input int cyc);
        ms_t n;
        int  p;
        n = s;
        p = period(mx, dw);
        if (rst) begin
            n.mode = M_IDLE;
            n.t    = 0;
            n.rem  = 0;
        end else begin
            case (s.mode)
                M_IDLE: begin
                    if (st && !sp) begin
                        n.mode = M_RUN;
                        n.t    = 0;
                        n.rem  = cyc;
                    end
                end
                M_RUN: begin
                    if (sp) begin
                        n.mode = M_IDLE;
                    end else begin
                        n.t = s.t + 1;
                        if (n.t == p) begin
                            n.t = 0;
                            if (n.rem != 0) n.rem = n.rem - 1;
                        end
                        if (n.rem == 1 && n.t == p - 1) n.mode = M_DONE;
                    end
                end
                default: n.mode = M_IDLE;
            endcase
        end
        return n;
    endfunction

    function automatic int exp_out(input ms_t s, input int mx, input int dw);
        int t;
        t = s.t;
        if (s.mode != M_RUN) return 0;
        if (t < mx) return t + 1;
        if (t < mx - 1 + dw) return mx;
        if (t < mx - 1 + dw + mx) return mx - 1 - (t - (mx - 1 + dw));
        return 0;
    endfunction

    function automatic int exp_dir(input ms_t s, input int mx, input int dw);
        return (s.mode == M_RUN && s.t < mx - 1 + dw) ? 1 : 0;
    endfunction

    always @(posedge Clock) begin
        m0 <= step(m0, 15, 2, Reset, Start, Stop, int'(Cycles));
        m1 <= step(m1, 7, 1, Reset, Start, Stop, int'(Cycles));
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge Clock) begin
        if (chk_en) begin
            chk("m0_out",  32'(out0),  32'(exp_out(m0, 15, 2)));
            chk("m0_dir",  32'(dir0),  32'(exp_dir(m0, 15, 2)));
            chk("m0_busy", 32'(busy0), 32'(m0.mode == M_RUN));
            chk("m0_done", 32'(done0), 32'(m0.mode == M_DONE));
            chk("m1_out",  32'(out1),  32'(exp_out(m1, 7, 1)));
            chk("m1_dir",  32'(dir1),  32'(exp_dir(m1, 7, 1)));
            chk("m1_busy", 32'(busy1), 32'(m1.mode == M_RUN));
            chk("m1_done", 32'(done1), 32'(m1.mode == M_DONE));
        end
    end

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic idle_gap(input int n);
        Start = 1'b0;
        Stop  = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset held for two edges.
        tick();
        tick();
        chk("rst_out", 32'(out0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_dir", 32'(dir0), 32'd0);
        Reset  = 1'b0;
        chk_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_out", 32'(out0), 32'd0);
            chk("idle_busy", 32'(busy0), 32'd0);
        end

        // Single period, literal timing pins.
        Cycles = 4'd1;
        Start  = 1'b1;
        tick();
        Start = 1'b0;
        for (int k = 0; k <= 33; k++) begin
            if (k == 0)  chk("c1_out_e0", 32'(out0), 32'd1);
            if (k == 0)  chk("c1_dir_e0", 32'(dir0), 32'd1);
            if (k == 14) chk("c1_out_e14", 32'(out0), 32'd15);
            if (k == 15) chk("c1_out_e15", 32'(out0), 32'd15);
            if (k == 16) chk("c1_out_e16", 32'(out0), 32'd14);
            if (k == 16) chk("c1_dir_e16", 32'(dir0), 32'd0);
            if (k == 30) chk("c1_out_e30", 32'(out0), 32'd0);
            if (k == 30) chk("c1_done_e30", 32'(done0), 32'd0);
            if (k == 31) chk("c1_done_e31", 32'(done0), 32'd1);
            if (k == 31) chk("c1_busy_e31", 32'(busy0), 32'd0);
            if (k == 32) chk("c1_done_e32", 32'(done0), 32'd0);
            if (k == 6)  chk("w3_out_e6", 32'(out1), 32'd7);
            if (k == 7)  chk("w3_out_e7", 32'(out1), 32'd6);
            if (k == 12) chk("w3_done_e12", 32'(done1), 32'd0);
            if (k == 13) chk("w3_done_e13", 32'(done1), 32'd1);
            // Start during the up ramp must be ignored.
            Start = (k == 5);
            tick();
        end
        idle_gap(4);

        // Three periods.
        Cycles = 4'd3;
        Start  = 1'b1;
        tick();
        Start  = 1'b0;
        Cycles = 4'd0;
        for (int k = 0; k <= 98; k++) begin
            if (k == 0 || k == 32 || k == 64) chk("c3_out_restart", 32'(out0), 32'd1);
            if (k == 94) chk("c3_done_e94", 32'(done0), 32'd0);
            if (k == 95) chk("c3_done_e95", 32'(done0), 32'd1);
            if (k == 96) chk("c3_busy_e96", 32'(busy0), 32'd0);
            tick();
        end
        idle_gap(4);

        // Free-running, stopped after edge 40.
        Cycles = 4'd0;
        Start  = 1'b1;
        tick();
        Start = 1'b0;
        for (int k = 0; k < 40; k++) tick();
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        chk("stop_out", 32'(out0), 32'd0);
        chk("stop_busy", 32'(busy0), 32'd0);
        idle_gap(4);

        // Start together with Stop in IDLE.
        Start = 1'b1;
        Stop  = 1'b1;
        tick();
        chk("startstop_busy", 32'(busy0), 32'd0);
        chk("startstop_out", 32'(out0), 32'd0);
        idle_gap(4);

        // Reset in the middle of the down ramp at Out=9.
        Cycles = 4'd0;
        Start  = 1'b1;
        tick();
        Start = 1'b0;
        for (int k = 0; k < 21; k++) tick();
        chk("pre_rst_out", 32'(out0), 32'd9);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("mid_rst_out", 32'(out0), 32'd0);
        chk("mid_rst_busy", 32'(busy0), 32'd0);
        chk("mid_rst_dir", 32'(dir0), 32'd0);
        idle_gap(4);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            Start = ($urandom_range(0, 9) < 3);
            Stop  = ($urandom_range(0, 63) == 0);
            Reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) Cycles = 4'($urandom_range(0, 15));
            else Cycles = 4'($urandom_range(0, 3));
            tick();
        end
        Reset = 1'b0;
        idle_gap(4);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cont2_ctrl.md
# cont2_ctrl

Sequencing controller for the 4-bit "type 2" up/down counter datapath. It starts, stops and repeats the triangular count pattern. Each cycle counts up to the maximum, holds there, counts down to zero and holds again. The block is driven by a start/stop command interface and a programmable repeat count, and it reports its status through Busy/Done. It sits between the stimulus/control logic and the counter output consumed downstream.

## Interface
- WIDTH, 4: counter width; MAX = 2**WIDTH-1.
- DWELL, 2: cycles Out is held at MAX and at 0 between ramps; legal range 1..15 (elaboration error otherwise).
- Clock  in  1  single clock, rising edge.
- Reset  in  1  synchronous, active-high; overrides all other inputs.
- Start  in  1  begin a run; sampled only in IDLE.
- Stop   in  1  abort a run; sampled in every state.
- Cycles in  4  number of full up/down cycles, latched on accepted Start; 0 = run until Stop.
- Out    out WIDTH  counter value.
- Dir    out 1  1 while ramping up or holding at MAX, 0 otherwise.
- Busy   out 1  run in progress.
- Done   out 1  one-cycle pulse on normal completion.

## Operation
- States: IDLE, UP, TOP, DOWN, BOTTOM, DONE.
- Reset: state IDLE, Out=0, Dir=0, Busy=0, Done=0, loop and dwell counters 0.
- IDLE: Out=0, Busy=0.
  - Start=1 and Stop=0 -> UP; Out<=1, Dir<=1, Busy<=1; latch Cycles.
  - Start=1 and Stop=1 -> stay IDLE.
- UP: Out<=Out+1 each edge.
  - On the edge where Out becomes MAX -> TOP; dwell counter <= DWELL-1.
- TOP: Out held at MAX.
  - Dwell counter 0 -> DOWN; Out<=MAX-1, Dir<=0.
  - Otherwise decrement the dwell counter.
- DOWN: Out<=Out-1.
  - On the edge where Out becomes 0 -> BOTTOM; dwell counter <= DWELL-1.
- BOTTOM: Out held at 0.
  - On dwell expiry with latched count ==1 -> DONE; Done<=1, Busy<=0.
  - On dwell expiry otherwise -> UP; Out<=1, Dir<=1; count decremented, except when latched count is 0, which never decrements.
- DONE: Out=0; next edge -> IDLE, Done<=0.
  - Start is ignored in DONE.
- Stop=1 in UP/TOP/DOWN/BOTTOM -> IDLE next edge; Out<=0, Dir<=0, Busy<=0. Done stays 0.
- Stop=1 in DONE: DONE completes normally (Done pulse already issued).
- Start while Busy is ignored. Cycles changes mid-run are ignored.
- Arithmetic never wraps. The FSM guarantees no increment at MAX and no decrement at 0. The datapath does not saturate.

## Timing
- Let edge 0 be the edge at which Start is accepted.
- Out=1 after edge 0. Out=k after edge k-1 for 1..MAX.
- Defaults (WIDTH=4, DWELL=2):
  - Out=15 after edges 14..15.
  - Out=14 after edge 16, descending to Out=0 after edge 30.
  - Out=0 held after edges 30..31.
  - Next cycle: Out=1 after edge 32.
- Period = 2*(MAX-1) + 2*DWELL cycles (32 at defaults).
- Completion: with Cycles=N, Done=1 after edge 32*N-1 (defaults) for exactly one cycle. IDLE is reached one edge later.
- Busy falls on the same edge Done rises.
- Stop latency: 1 edge. Reset latency: 1 edge, from any state.
- All outputs are registered; no combinational input-to-output path.

## Structure
- Package cont2_pkg holds:
  - typedef enum state_t {IDLE, UP, TOP, DOWN, BOTTOM, DONE};
  - default WIDTH and DWELL localparams;
  - function cycle_len(width, dwell) for benches.
- Sub-module cont_updown(Clock, Reset, Load, LoadVal, Inc, Dec, Q) is the counter datapath.
  - Load has priority over Inc, Inc over Dec.
  - The controller drives Load/Inc/Dec from the FSM; Out = Q.
- Dwell counter and loop counter are local to cont2_ctrl.

## Test plan
- Reset held 2 cycles, then released with Start=0 -> Out=0, Busy=0, Done=0, Dir=0 for 10 cycles.
- Start pulse with Cycles=1 (defaults):
  - Out follows 1..15,15,14..0,0.
  - Done=1 only after edge 31; Busy=0 from edge 31; IDLE after edge 32.
- Cycles=3 -> three identical 32-cycle periods, then one Done pulse after edge 95; Out=1 after edges 0, 32, 64.
- Cycles=0, Stop asserted after edge 40 -> Out=0, Busy=0 after edge 41; Done never asserts.
- Edge cases:
  - Start during UP is ignored; sequence unchanged.
  - Start+Stop together in IDLE -> remains IDLE.
  - Reset asserted while Out=9 in DOWN -> all outputs at reset values next edge.
- DWELL=1, WIDTH=3:
  - Out follows 1..7,6..0, period 14.
  - Done after edge 13 with Cycles=1.
